// File: rtl/frame_dispatch_ctrl.sv
// Frame dispatcher: pops a descriptor, waits until every destination port has room,
// then streams (or discards) the frame's data bytes and keeps saturating statistics.
module frame_dispatch_ctrl (
    input  logic        clk_sys,
    input  logic        rstn_sys,
    input  logic        ptr_sfifo_empty,
    output logic        ptr_sfifo_rd,
    input  logic [19:0] ptr_sfifo_dout,
    output logic        sfifo_rd,
    input  logic [7:0]  sfifo_dout,
    input  logic [3:0]  port_rdy,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic [3:0]  out_port_mask,
    output logic [3:0]  out_src_port,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt,
    output logic        busy
);

    typedef enum logic [7:0] {
        ST_IDLE  = 8'b0000_0001,
        ST_POP   = 8'b0000_0010,
        ST_LATCH = 8'b0000_0100,
        ST_CHECK = 8'b0000_1000,
        ST_XFER  = 8'b0001_0000,
        ST_DROP  = 8'b0010_0000,
        ST_DRAIN = 8'b0100_0000,
        ST_DONE  = 8'b1000_0000
    } state_t;

    state_t      state_r;
    logic        armed_r;
    logic [3:0]  mask_r;
    logic [3:0]  src_r;
    logic [10:0] len_r;
    logic [10:0] cnt_r;
    logic        xfer_r;
    logic        drain_cnt_r;
    logic        ptr_rd_r;
    logic        sfifo_rd_r;
    logic        busy_r;
    logic [15:0] frame_cnt_r;
    logic [15:0] drop_cnt_r;
    logic [3:0]  out_mask_r;
    logic [3:0]  out_src_r;

    logic        rd_d1_r;
    logic        sop_d1_r;
    logic        eop_d1_r;
    logic        out_valid_r;
    logic        out_sop_r;
    logic        out_eop_r;
    logic [7:0]  out_data_r;

    logic        xfer_rd_s;
    logic        first_rd_s;
    logic        last_rd_s;
    logic        rsvd_unused_s;

    // Saturating increment for the statistics counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    assign rsvd_unused_s = ptr_sfifo_dout[11];

    // Classify the current data read for the output pipeline.
    always_comb begin
        xfer_rd_s  = 1'b0;
        first_rd_s = 1'b0;
        last_rd_s  = 1'b0;
        if (state_r == ST_XFER && sfifo_rd_r) begin
            xfer_rd_s  = 1'b1;
            first_rd_s = (cnt_r == len_r);
            last_rd_s  = (cnt_r == 11'd1);
        end else begin
            xfer_rd_s  = 1'b0;
            first_rd_s = 1'b0;
            last_rd_s  = 1'b0;
        end
    end

    // Dispatch FSM with its registered control outputs and statistics.
    always_ff @(posedge clk_sys or negedge rstn_sys) begin
        if (!rstn_sys) begin
            state_r     <= ST_IDLE;
            armed_r     <= 1'b0;
            mask_r      <= 4'd0;
            src_r       <= 4'd0;
            len_r       <= 11'd0;
            cnt_r       <= 11'd0;
            xfer_r      <= 1'b0;
            drain_cnt_r <= 1'b0;
            ptr_rd_r    <= 1'b0;
            sfifo_rd_r  <= 1'b0;
            busy_r      <= 1'b0;
            frame_cnt_r <= 16'd0;
            drop_cnt_r  <= 16'd0;
            out_mask_r  <= 4'd0;
            out_src_r   <= 4'd0;
        end else begin
            // The arming flop keeps every strobe quiet in the first cycle after reset release.
            armed_r <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (armed_r && !ptr_sfifo_empty) begin
                        state_r  <= ST_POP;
                        ptr_rd_r <= 1'b1;
                        busy_r   <= 1'b1;
                    end
                end
                ST_POP: begin
                    ptr_rd_r <= 1'b0;
                    state_r  <= ST_LATCH;
                end
                ST_LATCH: begin
                    mask_r  <= ptr_sfifo_dout[19:16];
                    src_r   <= ptr_sfifo_dout[15:12];
                    len_r   <= ptr_sfifo_dout[10:0];
                    state_r <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (len_r == 11'd0) begin
                        xfer_r  <= 1'b0;
                        state_r <= ST_DONE;
                    end else if (mask_r == 4'd0) begin
                        xfer_r     <= 1'b0;
                        cnt_r      <= len_r;
                        sfifo_rd_r <= 1'b1;
                        state_r    <= ST_DROP;
                    end else if ((port_rdy & mask_r) == mask_r) begin
                        xfer_r     <= 1'b1;
                        cnt_r      <= len_r;
                        sfifo_rd_r <= 1'b1;
                        out_mask_r <= mask_r;
                        out_src_r  <= src_r;
                        state_r    <= ST_XFER;
                    end
                end
                ST_XFER, ST_DROP: begin
                    if (cnt_r == 11'd1) begin
                        sfifo_rd_r  <= 1'b0;
                        drain_cnt_r <= 1'b0;
                        state_r     <= ST_DRAIN;
                    end else begin
                        cnt_r <= cnt_r - 11'd1;
                    end
                end
                ST_DRAIN: begin
                    // Two drain cycles let the last byte leave the output pipeline under its mask.
                    if (drain_cnt_r) begin
                        out_mask_r <= 4'd0;
                        out_src_r  <= 4'd0;
                        state_r    <= ST_DONE;
                    end else begin
                        drain_cnt_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (xfer_r) begin
                        frame_cnt_r <= sat_inc(frame_cnt_r);
                    end else begin
                        drop_cnt_r <= sat_inc(drop_cnt_r);
                    end
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ptr_rd_r   <= 1'b0;
                    sfifo_rd_r <= 1'b0;
                    busy_r     <= 1'b0;
                    out_mask_r <= 4'd0;
                    out_src_r  <= 4'd0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    // Output byte pipeline: FIFO read latency plus one output register stage.
    always_ff @(posedge clk_sys or negedge rstn_sys) begin
        if (!rstn_sys) begin
            rd_d1_r     <= 1'b0;
            sop_d1_r    <= 1'b0;
            eop_d1_r    <= 1'b0;
            out_valid_r <= 1'b0;
            out_sop_r   <= 1'b0;
            out_eop_r   <= 1'b0;
            out_data_r  <= 8'd0;
        end else begin
            rd_d1_r     <= xfer_rd_s;
            sop_d1_r    <= first_rd_s;
            eop_d1_r    <= last_rd_s;
            out_valid_r <= rd_d1_r;
            out_sop_r   <= sop_d1_r;
            out_eop_r   <= eop_d1_r;
            if (rd_d1_r) begin
                out_data_r <= sfifo_dout;
            end
        end
    end

    assign ptr_sfifo_rd  = ptr_rd_r;
    assign sfifo_rd      = sfifo_rd_r;
    assign out_valid     = out_valid_r;
    assign out_data      = out_data_r;
    assign out_sop       = out_sop_r;
    assign out_eop       = out_eop_r;
    assign out_port_mask = out_mask_r;
    assign out_src_port  = out_src_r;
    assign frame_cnt     = frame_cnt_r;
    assign drop_cnt      = drop_cnt_r;
    assign busy          = busy_r;

endmodule

// File: doc/frame_dispatch_ctrl.md
FRAME_DISPATCH_CTRL -- requirements
Module: frame_dispatch_ctrl

Interface
REQ-001 SHALL have port clk_sys, input, 1: system clock; all logic on the rising edge.
REQ-002 SHALL have port rstn_sys, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port ptr_sfifo_empty, input, 1: descriptor FIFO empty.
REQ-004 SHALL have port ptr_sfifo_rd, output, 1: descriptor FIFO pop.
REQ-005 SHALL have port ptr_sfifo_dout, input, 20: descriptor, valid 1 cycle after pop; [19:16] dest mask, [15:12] source one-hot, [11] reserved, [10:0] byte length.
REQ-006 SHALL have port sfifo_rd, output, 1: data FIFO pop.
REQ-007 SHALL have port sfifo_dout, input, 8: data byte, valid 1 cycle after pop.
REQ-008 SHALL have port port_rdy, input, 4: per-output-port room for one maximum-size frame.
REQ-009 SHALL have the following output ports:
- out_valid, 1: byte strobe.
- out_data, 8: frame byte.
- out_sop, 1: first byte.
- out_eop, 1: last byte.
- out_port_mask, 4: destination mask, held for the whole frame.
- out_src_port, 4: source one-hot, held for the whole frame.
REQ-010 SHALL have output ports frame_cnt, 16 and drop_cnt, 16: saturating statistics counters.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-012 SHALL implement the following one-hot FSM:
- IDLE -> POP when !ptr_sfifo_empty.
- POP -> LATCH.
- LATCH -> CHECK.
- CHECK -> DONE if len==0.
- CHECK -> DROP if mask==0.
- CHECK -> XFER when (port_rdy & mask)==mask; otherwise stay in CHECK.
- XFER/DROP -> DRAIN after len read cycles.
- DRAIN -> DONE after 2 cycles.
- DONE -> IDLE.
REQ-013 SHALL assert ptr_sfifo_rd for exactly one cycle, in POP only.
REQ-014 SHALL capture the descriptor in LATCH; the captured len is 11 bits, and bit 11 is ignored.
REQ-015 SHALL sample port_rdy only in CHECK; deassertion during XFER SHALL NOT stall or abort the frame.
REQ-016 SHALL assert sfifo_rd for exactly len consecutive cycles in XFER or DROP, using an 11-bit down-counter loaded with len and ending at 1.
REQ-017 SHALL register out_data from sfifo_dout; out_valid is sfifo_rd delayed 2 cycles in XFER only.
REQ-018 SHALL assert out_sop with the first out_valid and out_eop with the len-th; for len==1 both SHALL be asserted on the same cycle.
REQ-019 SHALL keep out_valid low throughout DROP; the data bytes are consumed and discarded.
REQ-020 SHALL drive out_port_mask and out_src_port from the latched descriptor for the entire XFER/DRAIN window.
REQ-021 SHALL increment frame_cnt in DONE after XFER, and drop_cnt in DONE after DROP or after len==0.
REQ-022 SHALL hold both counters at 0xFFFF once reached (saturating, no wrap).
REQ-023 SHALL NOT issue sfifo_rd for a len==0 descriptor.
REQ-024 SHALL start a new POP no earlier than the cycle after DONE, leaving at least 1 idle cycle between frames.
REQ-025 SHALL treat ptr_sfifo_empty as don't-care outside IDLE.
REQ-026 SHALL NOT gate sfifo_rd on data FIFO emptiness; the producer guarantees that data is present when the descriptor is present.

Reset
REQ-027 SHALL, on rstn_sys low, asynchronously drive:
- state = IDLE.
- ptr_sfifo_rd = 0, sfifo_rd = 0, out_valid = 0, out_sop = 0, out_eop = 0.
- out_data = 0, out_port_mask = 0, out_src_port = 0.
- frame_cnt = 0, drop_cnt = 0, busy = 0.
REQ-028 SHALL, on reset asserted mid-frame, abandon the frame with no further FIFO pops; recovery is the system's responsibility.
REQ-029 SHALL NOT assert any output strobe in the first cycle after reset release.

Verification
REQ-030 SHALL cover this scenario: descriptor 0x3_1_0_040 (mask 0011, src 0001, len 64), port_rdy=1111 -> 1 ptr pop, 64 sfifo_rd cycles, 64 out_valid bytes, sop on byte 1, eop on byte 64, frame_cnt=1.
REQ-031 SHALL cover this scenario: mask=0100, len=10, port_rdy=0000 for 20 cycles then 0100 -> no sfifo_rd while held in CHECK, then 10 bytes out, out_port_mask=0100.
REQ-032 SHALL cover this scenario: mask=0000, len=5 -> 5 sfifo_rd cycles, out_valid never high, drop_cnt=1, frame_cnt unchanged.
REQ-033 SHALL cover this scenario: len=0, then len=1 -> first descriptor gives no sfifo_rd and drop_cnt=1; second gives a single byte with sop=eop=1.
REQ-034 SHALL cover this scenario: len=2047, port_rdy dropped mid-XFER -> all 2047 bytes contiguous with no gaps.
REQ-035 SHALL cover this scenario: frame_cnt preloaded near 0xFFFF via 65536 short frames -> stays at 0xFFFF; reset asserted mid-XFER -> all outputs 0 immediately.
